// File: rtl/alu_slice_exec.sv
`default_nettype none
// ============================================================================
// Module   : alu_slice_exec
// Brief    : Multi-cycle RV32I ALU; one SLICE_W-bit slice per cycle with a
//            registered carry chain behind valid/ready handshakes.
//            Optional macro ALU_LOGIC_FASTPATH_EN: AND/OR finish in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module alu_slice_exec #(
  parameter int SLICE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  ALUControl,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ALUResult,
  output logic        Zero,
  output logic        illegal
);

  localparam int c_NSL  = 32 / SLICE_W;
  localparam int c_SL_W = (c_NSL > 1) ? $clog2(c_NSL) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_SLT = 3'b101;

  logic [1:0]        r_state;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [2:0]        r_op;
  logic              r_carry;
  logic [c_SL_W-1:0] r_sl;
  logic [31:0]       r_result;
  logic              r_zero;
  logic              r_illegal;
  logic              r_out_valid;

  logic               w_in_legal;
  logic               w_in_sub;
  logic               w_invert;
  logic               w_is_logic;
  logic               w_last;
  logic [4:0]         w_base;
  logic [SLICE_W-1:0] w_a_sl;
  logic [SLICE_W-1:0] w_b_sl;
  logic [SLICE_W:0]   w_sum;
  logic [SLICE_W-1:0] w_slice_res;
  logic               w_slice_zero;
  logic               w_n;
  logic               w_v;
  logic               w_lt;

  assign w_in_legal = (ALUControl == c_OP_ADD) || (ALUControl == c_OP_SUB) ||
                      (ALUControl == c_OP_AND) || (ALUControl == c_OP_OR)  ||
                      (ALUControl == c_OP_SLT);
  assign w_in_sub   = (ALUControl == c_OP_SUB) || (ALUControl == c_OP_SLT);
  assign w_invert   = (r_op == c_OP_SUB) || (r_op == c_OP_SLT);
  assign w_is_logic = (r_op == c_OP_AND) || (r_op == c_OP_OR);
  assign w_last     = (r_sl == c_SL_W'(c_NSL - 1));

  // Slice base never exceeds 32-SLICE_W, so 5 bits always suffice.
  assign w_base = 5'(r_sl) * 5'(SLICE_W);
  assign w_a_sl = r_a[w_base +: SLICE_W];
  assign w_b_sl = w_invert ? ~r_b[w_base +: SLICE_W] : r_b[w_base +: SLICE_W];
  assign w_sum  = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE_W{1'b0}}, r_carry};

  always_comb begin
    w_slice_res = w_sum[SLICE_W-1:0];
    if (r_op == c_OP_AND) begin
      w_slice_res = w_a_sl & w_b_sl;
    end else if (r_op == c_OP_OR) begin
      w_slice_res = w_a_sl | w_b_sl;
    end
  end

  assign w_slice_zero = (w_slice_res == '0);

  // Signed compare from the top slice: N xor V of A - B.
  assign w_n  = w_sum[SLICE_W-1];
  assign w_v  = (w_a_sl[SLICE_W-1] == w_b_sl[SLICE_W-1]) && (w_n != w_a_sl[SLICE_W-1]);
  assign w_lt = w_n ^ w_v;

`ifdef ALU_LOGIC_FASTPATH_EN
  logic [31:0] w_full_logic;
  assign w_full_logic = (r_op == c_OP_AND) ? (r_a & r_b) : (r_a | r_b);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_carry     <= 1'b0;
      r_sl        <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (in_valid) begin
            r_a      <= SrcA;
            r_b      <= SrcB;
            r_op     <= ALUControl;
            r_sl     <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
            if (w_in_legal) begin
              r_carry   <= w_in_sub;
              r_illegal <= 1'b0;
              r_state   <= c_BUSY;
            end else begin
              r_carry   <= 1'b0;
              r_illegal <= 1'b1;
              r_state   <= c_DONE;
            end
          end
        end

        c_BUSY: begin
`ifdef ALU_LOGIC_FASTPATH_EN
          if (w_is_logic) begin
            r_result    <= w_full_logic;
            r_zero      <= (w_full_logic == '0);
            r_sl        <= '0;
            r_out_valid <= 1'b1;
            r_state     <= c_DONE;
          end else begin
`else
          begin
`endif
            r_result[w_base +: SLICE_W] <= w_slice_res;
            r_carry <= w_is_logic ? 1'b0 : w_sum[SLICE_W];
            r_zero  <= r_zero & w_slice_zero;
            if (w_last) begin
              r_sl        <= '0;
              r_out_valid <= 1'b1;
              r_state     <= c_DONE;
              if (r_op == c_OP_SLT) begin
                r_result <= {31'b0, w_lt};
                r_zero   <= ~w_lt;
              end
            end else begin
              r_sl <= r_sl + c_SL_W'(1);
            end
          end
        end

        c_DONE: begin
          // Illegal codes enter DONE straight from IDLE; valid follows one cycle later.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= c_IDLE;
          end
        end

        default: begin
          r_state     <= c_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == c_IDLE);
  assign out_valid = r_out_valid;
  assign ALUResult = r_result;
  assign Zero      = r_zero;
  assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_slice_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_slice_exec
// Brief    : Directed vector table plus backpressure and reset-abort sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_slice_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ALU_LOGIC_FASTPATH_EN
  localparam int c_LOGIC_LAT = 1;
`else
  localparam int c_LOGIC_LAT = 4;
`endif

  alu_slice_exec #(.SLICE_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    @(negedge clk);
    chk({v.name, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    ALUControl = v.op;
    SrcA       = v.a;
    SrcB       = v.b;
    @(negedge clk);
    in_valid   = 1'b0;
    ALUControl = 3'b111;
    SrcA       = $urandom;
    SrcB       = $urandom;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({v.name, " latency"}, 32'(lat), 32'(v.lat));
    chk({v.name, " result"}, ALUResult, v.res);
    chk({v.name, " zero"}, 32'(Zero), 32'(v.zero));
    chk({v.name, " illegal"}, 32'(illegal), 32'(v.ill));
    chk({v.name, " in_ready done"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({v.name, " back to idle"}, 32'(in_ready), 32'd1);
    chk({v.name, " out_valid drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    vecs[0]  = '{"add_ovf",   3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 4};
    vecs[1]  = '{"sub_eq",    3'b001, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 4};
    vecs[2]  = '{"add_wrap",  3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 4};
    vecs[3]  = '{"slt_neg",   3'b101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 4};
    vecs[4]  = '{"slt_ovf",   3'b101, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 4};
    vecs[5]  = '{"slt_eq",    3'b101, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 4};
    vecs[6]  = '{"slt_min",   3'b101, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 4};
    vecs[7]  = '{"and",       3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, c_LOGIC_LAT};
    vecs[8]  = '{"or",        3'b011, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, c_LOGIC_LAT};
    vecs[9]  = '{"sub_neg",   3'b001, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 4};
    vecs[10] = '{"ill_110",   3'b110, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b1, 1};
    vecs[11] = '{"ill_100",   3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, 1};
    vecs[12] = '{"add_carry", 3'b000, 32'h00FF00FF, 32'h00010001, 32'h01000100, 1'b0, 1'b0, 4};

    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ALUControl = 3'b000;
    SrcA       = '0;
    SrcB       = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", ALUResult, 32'd0);
    chk("reset zero", 32'(Zero), 32'd0);
    chk("reset illegal", 32'(illegal), 32'd0);

    for (int i = 0; i < 13; i++) run_op(vecs[i]);

    // Backpressure: result held, second request ignored while DONE.
    @(negedge clk);
    in_valid = 1'b1; ALUControl = 3'b000; SrcA = 32'd3; SrcB = 32'd4;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp latency", 32'(lat), 32'd4);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; ALUControl = 3'b000; SrcA = 32'd100; SrcB = 32'd1;
      @(negedge clk);
      chk("bp result held", ALUResult, 32'd7);
      chk("bp out_valid held", 32'(out_valid), 32'd1);
      chk("bp in_ready low", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp idle", 32'(in_ready), 32'd1);
    chk("bp out_valid drop", 32'(out_valid), 32'd0);
    chk("bp no extra accept", ALUResult, 32'd7);

    // Reset during BUSY after the second slice edge.
    @(negedge clk);
    in_valid = 1'b1; ALUControl = 3'b000; SrcA = 32'h11111111; SrcB = 32'h22222222;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort result", ALUResult, 32'd0);
    chk("abort zero", 32'(Zero), 32'd0);
    run_op('{"post_abort", 3'b000, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 1'b0, 4});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
